// File: rtl/accum32_stream.sv
// ---------------------------------------------------------------------------
// accum32_stream
//   Streaming 32-bit unsigned block accumulator. Sums blocks of BLOCK_LEN
//   samples and presents each block total with a sticky overflow flag on a
//   valid/ready result port. Every add is done as two 16-bit halves joined
//   by a carry; the carry out of bit 31 only feeds the overflow flag.
//   A block closes on the BLOCK_LEN-th accepted sample, or early on flush
//   when the block holds at least one sample (including one accepted in the
//   same cycle). While a result is pending the input is stalled.
//
// Configuration macro:
//   ACCUM32_SATURATE_EN - when defined, the running sum clamps to
//                         32'hFFFF_FFFF after the first carry out of bit 31
//                         and stays clamped for the rest of the block.
//                         When undefined, the sum wraps mod 2^32.
//
// Ports:
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous reset, active-high
//   in_valid     in   1   in_data holds a sample
//   in_ready     out  1   sample accepted when in_valid & in_ready
//   in_data      in   32  unsigned sample
//   flush        in   1   close the current block early (level)
//   out_valid    out  1   result valid, held until out_ready
//   out_ready    in   1   consumer takes the result
//   out_sum      out  32  block total
//   out_overflow out  1   some add in the block carried out of bit 31
//   busy         out  1   block in progress or result pending
// ---------------------------------------------------------------------------
module accum32_stream #(
   parameter int BLOCK_LEN = 8,
   parameter int CNT_W     = $clog2(BLOCK_LEN + 1)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_sum,
   output logic        out_overflow,
   output logic        busy
);

   localparam logic [0:0]       ST_ACCUM    = 1'b0;
   localparam logic [0:0]       ST_HOLD     = 1'b1;
   localparam logic [CNT_W-1:0] BLOCK_LEN_C = CNT_W'(BLOCK_LEN);
   localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   // Two-half add: returns {carry out of bit 31, 32-bit sum}.
   function automatic logic [32:0] add_split(input logic [31:0] a, input logic [31:0] b);
      logic [16:0] lo;
      logic [16:0] hi;
      lo = {1'b0, a[15:0]} + {1'b0, b[15:0]};
      hi = {1'b0, a[31:16]} + {1'b0, b[31:16]} + {16'd0, lo[16]};
      return {hi[16], hi[15:0], lo[15:0]};
   endfunction

   logic [0:0]       state_q,        state_d;
   logic [31:0]      acc_q,          acc_d;
   logic             ovf_q,          ovf_d;
   logic [CNT_W-1:0] count_q,        count_d;
   logic             out_valid_q,    out_valid_d;
   logic [31:0]      out_sum_q,      out_sum_d;
   logic             out_overflow_q, out_overflow_d;
   logic             in_ready_q,     in_ready_d;
   logic             busy_q,         busy_d;

   logic             accept_s;
   logic [32:0]      add_s;
   logic [31:0]      acc_next_s;
   logic             ovf_next_s;
   logic [CNT_W-1:0] count_inc_s;
   logic [CNT_W-1:0] count_next_s;
   logic             close_s;

   // Post-accept accumulator view and block-close decision.
   always_comb begin
      accept_s    = in_valid & in_ready_q & (state_q == ST_ACCUM);
      add_s       = add_split(acc_q, in_data);
      count_inc_s = count_q + CNT_ONE;
      if (accept_s) begin
         ovf_next_s   = ovf_q | add_s[32];
`ifdef ACCUM32_SATURATE_EN
         // Sticky overflow keeps the sum pinned at all-ones for the block.
         acc_next_s   = ovf_next_s ? 32'hFFFF_FFFF : add_s[31:0];
`else
         acc_next_s   = add_s[31:0];
`endif
         count_next_s = count_inc_s;
      end else begin
         ovf_next_s   = ovf_q;
         acc_next_s   = acc_q;
         count_next_s = count_q;
      end
      // Flush only closes a non-empty block; a full block plus flush is one close.
      close_s = (state_q == ST_ACCUM) &&
                ((accept_s && (count_inc_s == BLOCK_LEN_C)) ||
                 (flush && ((count_q != CNT_ZERO) || accept_s)));
   end

   // Next-state logic for the ACCUM/HOLD controller and result registers.
   always_comb begin
      state_d        = state_q;
      acc_d          = acc_q;
      ovf_d          = ovf_q;
      count_d        = count_q;
      out_valid_d    = out_valid_q;
      out_sum_d      = out_sum_q;
      out_overflow_d = out_overflow_q;
      case (state_q)
         ST_ACCUM: begin
            acc_d   = acc_next_s;
            ovf_d   = ovf_next_s;
            count_d = count_next_s;
            if (close_s) begin
               out_sum_d      = acc_next_s;
               out_overflow_d = ovf_next_s;
               out_valid_d    = 1'b1;
               state_d        = ST_HOLD;
            end else begin
               out_valid_d    = 1'b0;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               acc_d       = 32'h0;
               ovf_d       = 1'b0;
               count_d     = CNT_ZERO;
               out_valid_d = 1'b0;
               state_d     = ST_ACCUM;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            acc_d       = 32'h0;
            ovf_d       = 1'b0;
            count_d     = CNT_ZERO;
            out_valid_d = 1'b0;
            state_d     = ST_ACCUM;
         end
      endcase
      // in_ready is registered, so it already reflects the coming state.
      in_ready_d = (state_d == ST_ACCUM);
      busy_d     = (count_d != CNT_ZERO) || out_valid_d;
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_ACCUM;
         acc_q          <= 32'h0;
         ovf_q          <= 1'b0;
         count_q        <= CNT_ZERO;
         out_valid_q    <= 1'b0;
         out_sum_q      <= 32'h0;
         out_overflow_q <= 1'b0;
         in_ready_q     <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         acc_q          <= acc_d;
         ovf_q          <= ovf_d;
         count_q        <= count_d;
         out_valid_q    <= out_valid_d;
         out_sum_q      <= out_sum_d;
         out_overflow_q <= out_overflow_d;
         in_ready_q     <= in_ready_d;
         busy_q         <= busy_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_sum      = out_sum_q;
   assign out_overflow = out_overflow_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_accum32_stream.sv
// ---------------------------------------------------------------------------
// tb_accum32_stream
//   Self-checking bench for accum32_stream (BLOCK_LEN = 8). Fixed vectors
//   from a table, hand-written corner sequences (back-to-back, stall, idle
//   flush, async reset), then random blocks checked against an exact-sum
//   model: the block total is computed in 64 bits, the result is its low
//   32 bits and the overflow flag is "exact total >= 2^32".
// ---------------------------------------------------------------------------
module tb_accum32_stream;

   localparam int BL = 8;
`ifdef ACCUM32_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic        out_overflow;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   accum32_stream #(.BLOCK_LEN(BL)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sum      (out_sum),
      .out_overflow (out_overflow),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          n;
      bit          fl;
      logic [31:0] d [8];
      logic [31:0] es;
      bit          eo;
   } vec_t;

   vec_t tbl [8];

   function automatic vec_t mk(input int n, input bit fl,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3,
                               input logic [31:0] w4, input logic [31:0] w5,
                               input logic [31:0] w6, input logic [31:0] w7,
                               input logic [31:0] es, input bit eo);
      vec_t v;
      v.n = n; v.fl = fl;
      v.d[0] = w0; v.d[1] = w1; v.d[2] = w2; v.d[3] = w3;
      v.d[4] = w4; v.d[5] = w5; v.d[6] = w6; v.d[7] = w7;
      v.es = es; v.eo = eo;
      return v;
   endfunction

   // Reference: exact block total -> expected out_sum
   function automatic logic [31:0] model_sum(input logic [63:0] tot);
      if (SAT && tot >= 64'h1_0000_0000) return 32'hFFFF_FFFF;
      return tot[31:0];
   endfunction

   function automatic logic model_ovf(input logic [63:0] tot);
      return (tot >= 64'h1_0000_0000);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one sample and wait (bounded) until it is accepted.
   task automatic push(input logic [31:0] d, input logic fl);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = d;
      flush    = fl;
      while (in_ready !== 1'b1 && guard < 20) begin
         step();
         guard++;
      end
      if (in_ready !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL push_timeout: in_ready %b, expected 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      flush    = 1'b0;
      in_data  = 32'h0;
   endtask

   // Check a pending result, then complete the output handshake.
   task automatic take(input string name, input logic [31:0] es, input logic eo);
      check({name, "_valid"}, {63'd0, out_valid}, 64'd1);
      check({name, "_sum"}, {32'd0, out_sum}, {32'd0, es});
      check({name, "_ovf"}, {63'd0, out_overflow}, {63'd0, eo});
      check({name, "_inrdy_hold"}, {63'd0, in_ready}, 64'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({name, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
      check({name, "_inrdy_back"}, {63'd0, in_ready}, 64'd1);
      check({name, "_busy_idle"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] held;
      logic [63:0] tot;
      logic [31:0] d;
      int          n;
      bit          fl;

      tbl[0] = mk(8, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd36, 1'b0);
      tbl[1] = mk(8, 1'b0, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                  SAT ? 32'hFFFF_FFFF : 32'h10, 1'b1);
      tbl[2] = mk(8, 1'b0, 32'h0000_FFFF, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                  32'h0001_0000, 1'b0);
      tbl[3] = mk(3, 1'b1, 32'd5, 32'd6, 32'd7, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd18, 1'b0);
      tbl[4] = mk(8, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  SAT ? 32'hFFFF_FFFF : 32'hFFFF_FFF8, 1'b1);
      tbl[5] = mk(1, 1'b1, 32'd42, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd42, 1'b0);
      tbl[6] = mk(8, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                  SAT ? 32'hFFFF_FFFF : 32'h0, 1'b1);
      tbl[7] = mk(8, 1'b1, 32'h0001_8000, 32'h0000_8000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                  32'h0002_0000, 1'b0);

      rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; flush = 1'b0; out_ready = 1'b0;

      // Reset state while rst is held across clock edges.
      step(); step();
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_sum", {32'd0, out_sum}, 64'd0);
      check("rst_out_ovf", {63'd0, out_overflow}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      rst = 1'b0;
      step();
      check("rst_release_in_ready", {63'd0, in_ready}, 64'd1);

      // Table-driven blocks.
      foreach (tbl[i]) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            push(tbl[i].d[k], tbl[i].fl && (k == tbl[i].n - 1));
            if (k < tbl[i].n - 1) check($sformatf("tbl%0d_early_valid", i), {63'd0, out_valid}, 64'd0);
         end
         take($sformatf("tbl%0d", i), tbl[i].es, tbl[i].eo);
      end

      // Back-to-back with out_ready held high: one-cycle out_valid.
      out_ready = 1'b1;
      for (int i = 1; i <= BL; i++) begin
         in_valid = 1'b1;
         in_data  = 32'(i);
         step();
      end
      in_valid = 1'b0;
      check("b2b_valid", {63'd0, out_valid}, 64'd1);
      check("b2b_sum", {32'd0, out_sum}, 64'd36);
      check("b2b_inrdy_low", {63'd0, in_ready}, 64'd0);
      step();
      check("b2b_valid_one_cycle", {63'd0, out_valid}, 64'd0);
      check("b2b_inrdy_back", {63'd0, in_ready}, 64'd1);
      out_ready = 1'b0;

      // Flush on an empty block with no sample does nothing.
      flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("idle_flush_valid", {63'd0, out_valid}, 64'd0);
         check("idle_flush_busy", {63'd0, busy}, 64'd0);
      end
      flush = 1'b0;

      // Result stalled for 4 cycles with a new sample waiting.
      for (int i = 0; i < BL; i++) push(32'd10, 1'b0);
      held     = out_sum;
      in_valid = 1'b1;
      in_data  = 32'd99;
      for (int i = 0; i < 4; i++) begin
         step();
         check("stall_valid", {63'd0, out_valid}, 64'd1);
         check("stall_sum", {32'd0, out_sum}, 64'd80);
         check("stall_sum_stable", {32'd0, out_sum}, {32'd0, held});
         check("stall_inrdy", {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("stall_release", {63'd0, out_valid}, 64'd0);
      push(32'd99, 1'b0);
      for (int i = 1; i < BL; i++) push(32'd1, 1'b0);
      take("after_stall", 32'd106, 1'b0);

      // Async reset mid-block.
      push(32'd100, 1'b0); push(32'd200, 1'b0); push(32'd300, 1'b0); push(32'd400, 1'b0);
      check("mid_busy", {63'd0, busy}, 64'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_busy", {63'd0, busy}, 64'd0);
      check("mid_rst_inrdy", {63'd0, in_ready}, 64'd0);
      check("mid_rst_sum", {32'd0, out_sum}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < BL; i++) push(32'd3, 1'b0);
      take("post_mid_rst", 32'd24, 1'b0);

      // Async reset while a result is held.
      for (int i = 0; i < BL; i++) push(32'hFFFF_FFFF, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("hold_rst_valid", {63'd0, out_valid}, 64'd0);
      check("hold_rst_sum", {32'd0, out_sum}, 64'd0);
      check("hold_rst_ovf", {63'd0, out_overflow}, 64'd0);
      check("hold_rst_busy", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      push(32'd7, 1'b0);
      push(32'd9, 1'b1);
      take("post_hold_rst", 32'd16, 1'b0);

      // Random blocks against the exact-sum model.
      for (int b = 0; b < 60; b++) begin
         n   = $urandom_range(1, BL);
         fl  = (n < BL) ? 1'b1 : bit'($urandom_range(0, 1));
         tot = 64'd0;
         if ($urandom_range(0, 3) == 0) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
            check("rnd_idle_flush", {63'd0, out_valid}, 64'd0);
         end
         for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 2))
               0:       d = 32'($urandom_range(0, 1000));
               1:       d = $urandom;
               default: d = 32'hF000_0000 | $urandom;
            endcase
            tot = tot + {32'd0, d};
            repeat ($urandom_range(0, 2)) step();
            push(d, fl && (k == n - 1));
         end
         repeat ($urandom_range(0, 3)) begin
            step();
            check("rnd_hold_valid", {63'd0, out_valid}, 64'd1);
         end
         take($sformatf("rnd%0d", b), model_sum(tot), model_ovf(tot));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
